// File: rtl/sw_debouncer.sv
// Two-flop synchroniser plus per-bit stable-level debouncer for board slide switches.
// Optional rise/fall pulse outputs are built when SW_EDGE_EN is defined.
module sw_debouncer #(
   parameter int WIDTH         = 4,
   parameter int STABLE_CYCLES = 1000000,
   parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw_in,
   output logic [WIDTH-1:0] sw_out,
   output logic             busy
`ifdef SW_EDGE_EN
   ,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic [WIDTH-1:0]            sync1_q, sync2_q;
   logic [WIDTH-1:0]            stb_q, stb_d;
   logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic                        busy_q, busy_d;

   always_comb begin
      stb_d = stb_q;
      cnt_d = cnt_q;
      for (int i = 0; i < WIDTH; i++) begin
         // A return to the accepted level drops any partial qualification.
         if (sync2_q[i] == stb_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            stb_d[i] = sync2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
      busy_d = |cnt_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         stb_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         sync1_q <= sw_in;
         sync2_q <= sync1_q;
         stb_q   <= stb_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

   assign sw_out = stb_q;
   assign busy   = busy_q;

`ifdef SW_EDGE_EN
   logic [WIDTH-1:0] rise_q, fall_q;

   // Pulses land on the same edge the stable level changes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         rise_q <= stb_d & ~stb_q;
         fall_q <= stb_q & ~stb_d;
      end
   end

   assign sw_rise = rise_q;
   assign sw_fall = fall_q;
`endif

endmodule

// File: tb/tb_sw_debouncer.sv
// Directed + random bench for sw_debouncer (WIDTH=4, STABLE_CYCLES=8) against a sample-window model.
module tb_sw_debouncer;
   localparam int W = 4;
   localparam int S = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] sw_in;
   logic [W-1:0] sw_out;
   logic         busy;
`ifdef SW_EDGE_EN
   logic [W-1:0] sw_rise, sw_fall;
`endif

   sw_debouncer #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .sw_in  (sw_in),
      .sw_out (sw_out),
      .busy   (busy)
`ifdef SW_EDGE_EN
      ,
      .sw_rise(sw_rise),
      .sw_fall(sw_fall)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Model: raw samples reach the debouncer two edges late; a bit flips once
   // its last S delayed samples all disagree with the accepted level.
   logic [W-1:0] pipe[$];
   logic [W-1:0] hist[$];
   logic [W-1:0] m_stb, m_rise, m_fall;
   logic         m_busy;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      pipe.delete();
      hist.delete();
      pipe.push_back('0);
      pipe.push_back('0);
      for (int k = 0; k < S; k++) hist.push_back('0);
      m_stb  = '0;
      m_rise = '0;
      m_fall = '0;
      m_busy = 1'b0;
   endtask

   task automatic model_edge(input logic [W-1:0] v);
      logic [W-1:0] ev, nstb;
      logic         all_diff;
      pipe.push_back(v);
      ev = pipe.pop_front();
      hist.push_back(ev);
      if (hist.size() > S) void'(hist.pop_front());
      nstb = m_stb;
      for (int b = 0; b < W; b++) begin
         all_diff = 1'b1;
         foreach (hist[k]) if (hist[k][b] == m_stb[b]) all_diff = 1'b0;
         if (all_diff) nstb[b] = ~m_stb[b];
      end
      m_rise = nstb & ~m_stb;
      m_fall = m_stb & ~nstb;
      m_stb  = nstb;
      m_busy = |(ev ^ m_stb);
   endtask

   task automatic check_model();
      chk("sw_out", 32'(sw_out), 32'(m_stb));
      chk("busy", 32'(busy), 32'(m_busy));
`ifdef SW_EDGE_EN
      chk("sw_rise", 32'(sw_rise), 32'(m_rise));
      chk("sw_fall", 32'(sw_fall), 32'(m_fall));
`endif
   endtask

   // Drive a value, let one rising edge sample it, then compare just after the edge.
   task automatic tick(input logic [W-1:0] v);
      sw_in = v;
      @(posedge clk);
      model_edge(v);
      #1;
      check_model();
   endtask

   // Asynchronous reset pulled between edges; outputs must clear immediately.
   task automatic async_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_sw_out", 32'(sw_out), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
`ifdef SW_EDGE_EN
      chk("rst_rise", 32'(sw_rise), 32'h0);
      chk("rst_fall", 32'(sw_fall), 32'h0);
`endif
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      logic [W-1:0] v, mask;
      rst_n = 1'b0;
      sw_in = '0;
      model_reset();
      #3;
      chk("por_sw_out", 32'(sw_out), 32'h0);
      chk("por_busy", 32'(busy), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) tick(4'b0000);

      // 1: clean rise
      for (int k = 0; k <= 12; k++) begin
         tick(4'b0101);
         if (k == 8) chk("t1_out_e8", 32'(sw_out), 32'h0);
         if (k == 9) chk("t1_out_e9", 32'(sw_out), 32'h5);
         if (k >= 2 && k <= 8) chk("t1_busy", 32'(busy), 32'h1);
         if (k == 1 || k == 9) chk("t1_busy_edge", 32'(busy), 32'h0);
`ifdef SW_EDGE_EN
         if (k == 9) chk("t1_rise_e9", 32'(sw_rise), 32'h5);
         if (k == 10) chk("t1_rise_e10", 32'(sw_rise), 32'h0);
`endif
      end

      // 2: bounce rejection on bit 0
      async_reset();
      repeat (3) tick(4'b0000);
      repeat (5) begin tick(4'b0001); chk("t2_out0", 32'(sw_out[0]), 32'h0); end
      repeat (2) begin tick(4'b0000); chk("t2_out0", 32'(sw_out[0]), 32'h0); end
      repeat (7) begin tick(4'b0001); chk("t2_out0", 32'(sw_out[0]), 32'h0); end
      repeat (12) begin tick(4'b0000); chk("t2_out0", 32'(sw_out[0]), 32'h0); end
      chk("t2_busy_idle", 32'(busy), 32'h0);

      // 3: accept after bounce on bit 3
      repeat (3) tick(4'b1000);
      tick(4'b0000);
      for (int k = 0; k <= 11; k++) begin
         tick(4'b1000);
         if (k == 8) chk("t3_out3_e8", 32'(sw_out[3]), 32'h0);
         if (k == 9) chk("t3_out3_e9", 32'(sw_out[3]), 32'h1);
      end

      // 4: independent bits
      async_reset();
      repeat (3) tick(4'b0000);
      for (int k = 0; k <= 15; k++) begin
         tick((k >= 4) ? 4'b0110 : 4'b0010);
         if (k == 8) chk("t4_out1_e8", 32'(sw_out[1]), 32'h0);
         if (k == 9) chk("t4_out1_e9", 32'(sw_out[1]), 32'h1);
         if (k == 12) chk("t4_out2_e12", 32'(sw_out[2]), 32'h0);
         if (k == 13) chk("t4_out2_e13", 32'(sw_out[2]), 32'h1);
         if (k >= 2 && k <= 12) chk("t4_busy", 32'(busy), 32'h1);
      end

      // 5: fall from all-ones
      repeat (12) tick(4'b1111);
      chk("t5_start", 32'(sw_out), 32'hF);
      for (int k = 0; k <= 11; k++) begin
         tick(4'b0000);
         if (k == 8) chk("t5_out_e8", 32'(sw_out), 32'hF);
         if (k == 9) chk("t5_out_e9", 32'(sw_out), 32'h0);
`ifdef SW_EDGE_EN
         if (k == 9) chk("t5_fall_e9", 32'(sw_fall), 32'hF);
         if (k == 10) chk("t5_fall_e10", 32'(sw_fall), 32'h0);
`endif
      end

      // 6: reset mid-qualification
      for (int k = 0; k <= 5; k++) tick(4'b1000);
      chk("t6_busy_pre", 32'(busy), 32'h1);
      async_reset();
      for (int k = 0; k <= 11; k++) begin
         tick(4'b1000);
         if (k == 8) chk("t6_out3_e8", 32'(sw_out[3]), 32'h0);
         if (k == 9) chk("t6_out3_e9", 32'(sw_out[3]), 32'h1);
      end

      // Random: fast bounce, then slow changes, with a reset in between
      v = 4'(($urandom));
      for (int k = 0; k < 300; k++) begin
         mask = '0;
         for (int b = 0; b < W; b++) if ($urandom_range(0, 3) == 0) mask[b] = 1'b1;
         v = v ^ mask;
         tick(v);
      end
      async_reset();
      for (int k = 0; k < 600; k++) begin
         mask = '0;
         for (int b = 0; b < W; b++) if ($urandom_range(0, 11) == 0) mask[b] = 1'b1;
         v = v ^ mask;
         tick(v);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/sw_debouncer.md
# sw_debouncer

Input-conditioning stage that sits directly upstream of the LED controller and drives its 4-bit switch input. It synchronises the raw board slide switches into the `clk` domain and debounces each bit independently. It presents a clean, registered switch vector so the LED stage never sees metastable or bouncing levels.

## Interface

**Parameters**
- `WIDTH`, default 4: number of switch bits handled.
- `STABLE_CYCLES`, default 1000000: consecutive `clk` cycles a synchronised bit must hold a new level before it is accepted (10 ms at 100 MHz). Legal range is 2 and above.
- `CNT_W`, default `$clog2(STABLE_CYCLES)`: width of each per-bit counter.

**Ports**
- `clk`, input, 1: system clock; all state updates on rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `sw_in`, input, `WIDTH`: raw switch pins, asynchronous to `clk`.
- `sw_out`, output, `WIDTH`: debounced switch levels; feeds the LED controller `sw` input.
- `busy`, output, 1: high while any bit's counter is non-zero, meaning a candidate change is being qualified.
- `sw_rise`, output, `WIDTH`: present only with `SW_EDGE_EN`; one-cycle pulse per bit on accepted 0→1.
- `sw_fall`, output, `WIDTH`: present only with `SW_EDGE_EN`; one-cycle pulse per bit on accepted 1→0.

## Operation

- **Synchroniser:** two flops per bit, `sync1` and then `sync2`.
- **Per-bit state:** stable level `stb[i]` drives `sw_out[i]`; counter `cnt[i]` is `CNT_W` bits wide.
- **Each edge, per bit:**
  - If `sync2[i] == stb[i]`, then `cnt[i]` is set to 0. Any partial qualification is discarded.
  - Else, if `cnt[i] == STABLE_CYCLES-1`, then `stb[i]` is set to `sync2[i]` and `cnt[i]` is set to 0.
  - Else, `cnt[i]` is set to `cnt[i] + 1`.
- Bits are fully independent. Simultaneous changes on several bits qualify in parallel with no interaction.
- A bounce that returns to the old level before qualification completes resets that bit's counter. No output change occurs.
- The counter never exceeds `STABLE_CYCLES-1`; there is no wrap-around path.
- `busy` is the registered OR of all `cnt[i] != 0`, computed from the post-update counter values.
- **Reset (`rst_n` low, asynchronous, any time including mid-qualification):**
  - `sync1`, `sync2`, `stb`, and `cnt` all go to 0.
  - `sw_out`, `busy`, `sw_rise`, and `sw_fall` all go to 0.
  - On release, a switch already held high is accepted as a normal 0→1 after full qualification. A rise pulse is generated for it when edges are enabled.
- `sw_in` is not sampled while `rst_n` is low.

## Timing

- Edge 0 is the first rising edge at which `sw_in[i]` is sampled at its new level.
  - `sync1` updates at edge 0.
  - `sync2` updates at edge 1.
  - Counter evaluations occur at edges 2 through `STABLE_CYCLES+1`.
  - `sw_out[i]` changes at edge `STABLE_CYCLES+1`.
- Total latency is `STABLE_CYCLES+2` edges inclusive of edge 0, provided the input is held steady.
- Minimum accepted pulse width at `sw_in` is `STABLE_CYCLES` cycles. Shorter pulses are rejected.
- `busy` rises at edge 2 and falls at edge `STABLE_CYCLES+1`, the same edge `sw_out` updates.
- Edge pulses are asserted at the same edge `sw_out` changes and deassert on the next edge.
- All outputs are registered. There are no combinational paths from `sw_in`.

## Configuration

- Macro: `SW_EDGE_EN`.
- **Defined:**
  - `sw_rise` and `sw_fall` ports and their registers exist.
  - `sw_rise[i] = ~stb_prev[i] & stb[i]` and `sw_fall[i] = stb_prev[i] & ~stb[i]`, registered in step with `stb`.
  - Both reset to 0.
- **Undefined:** the ports and their logic are absent; the rest of the behaviour is identical.

## Test plan

Use `STABLE_CYCLES=8` and `WIDTH=4` throughout.

1. **Clean rise:**
   - Stimulus: after reset, `sw_in` steps from 4'b0000 to 4'b0101 just before edge 0 and is held.
   - Required: `sw_out` reads 4'b0000 through edge 8 and 4'b0101 from edge 9.
   - Required: `busy` is high from edge 2 through edge 8.
   - Required (with `SW_EDGE_EN`): `sw_rise` is 4'b0101 for exactly one cycle at edge 9.
2. **Bounce rejection:**
   - Stimulus: bit 0 toggles high for 5 cycles, low for 2, then high for 7, then returns low.
   - Required: `sw_out[0]` stays 0 throughout.
   - Required: `busy` returns to 0 after each low interval reaches `sync2`.
3. **Accept after bounce:**
   - Stimulus: bit 3 bounces 3 cycles high, 1 low, then holds high.
   - Required: `sw_out[3]` goes to 1 exactly 9 edges after the final rising sample.
4. **Independent bits:**
   - Stimulus: bit 1 rises at edge 0 and bit 2 rises at edge 4, both held.
   - Required: `sw_out[1]` updates at edge 9 and `sw_out[2]` at edge 13.
   - Required: `busy` stays high continuously from edge 2 through edge 12.
5. **Fall with edge pulse:**
   - Stimulus: starting from `sw_out` = 4'b1111, `sw_in` goes to 4'b0000.
   - Required: `sw_out` reads 4'b0000 at edge 9.
   - Required (with `SW_EDGE_EN`): `sw_fall` is 4'b1111 for one cycle at edge 9.
6. **Reset mid-qualification:**
   - Stimulus: `sw_in` = 4'b1000; `rst_n` is pulled low asynchronously at edge 5 and released.
   - Required: all outputs read 0 immediately on the reset assertion.
   - Required: after release, `sw_out[3]` reaches 1 only after a full 9-edge requalification.
